// File: rtl/fb_pkg.sv
// fb_pkg -- shared definitions for the frame-buffer RAM arbiter slice.
//   FB_ADDR_W     : width of the frame RAM address bus
//   FB_FRAME_LAST : last pixel address of a 320x480 frame (153600 pixels)
//   fb_state_e    : arbiter FSM state encoding (IDLE / RD / WR)
package fb_pkg;

  localparam int FB_ADDR_W     = 18;
  localparam int FB_FRAME_LAST = 153599;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_addr_cnt.sv
// fb_addr_cnt -- frame address counter with enable and wrap.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, clears count to 0
//   en    : advance the counter by one this cycle
//   count : current address (the address the next access will use)
//   last  : high while count equals FRAME_LAST
module fb_addr_cnt
  import fb_pkg::*;
#(
  parameter int FRAME_LAST = FB_FRAME_LAST
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic [FB_ADDR_W-1:0] count,
  output logic                 last
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FRAME_LAST);

  assign last = (count == LAST_ADDR);

  // The counter only moves when its owner actually accesses the RAM, so
  // reader and writer positions stay independent of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/fb_ram_arbiter.sv
// fb_ram_arbiter -- shares one single-port frame RAM between the display
// reader and a single writer. Reads win unconditionally while the video
// timing says the active region is on; writes fill the remaining cycles.
// Optional feature macro: FB_ARB_STALL_CNT_EN (adds wr_stall_cnt).
// Ports:
//   clk            : sole clock, rising edge
//   Reset_Main     : synchronous active-high reset
//   VtcVde         : active video, one pixel read per cycle
//   wr_req/wr_data : writer request (held until wr_ack) and its pixel
//   wr_ack         : one-cycle pulse, write accepted
//   wr_frame_done  : one-cycle pulse, write to FRAME_LAST issued
//   ram_en/ram_we/ram_addr/ram_din : registered RAM port
//   rd_valid       : RAM read data valid (one cycle after each read)
//   rd_frame_start : one-cycle pulse, read of address 0 issued
//   wr_stall_cnt   : (FB_ARB_STALL_CNT_EN only) saturating count of
//                    cycles in which a write request was refused
module fb_ram_arbiter
  import fb_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FRAME_LAST = FB_FRAME_LAST
) (
  input  logic                 clk,
  input  logic                 Reset_Main,
  input  logic                 VtcVde,
  input  logic                 wr_req,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_ack,
  output logic                 wr_frame_done,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [FB_ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0]    ram_din,
  output logic                 rd_valid,
  output logic                 rd_frame_start
`ifdef FB_ARB_STALL_CNT_EN
  ,
  output logic [15:0]          wr_stall_cnt
`endif
);

  fb_state_e state, next_state;

  logic [FB_ADDR_W-1:0] rd_addr, wr_addr;
  logic                 wr_last;
  logic                 rd_last_unused;
  logic                 rd_go, wr_go;

  // State register: the state names the access that is on the RAM port
  // during the current cycle.
  always_ff @(posedge clk) begin
    if (Reset_Main) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next access is chosen purely from the current inputs; the display
  // reader has absolute priority so the pixel stream never starves.
  always_comb begin
    next_state = IDLE;
    if (VtcVde) begin
      next_state = RD;
    end else if (wr_req) begin
      next_state = WR;
    end
  end

  assign rd_go = (next_state == RD);
  assign wr_go = (next_state == WR);

  fb_addr_cnt #(.FRAME_LAST(FRAME_LAST)) u_rd_cnt (
    .clk   (clk),
    .reset (Reset_Main),
    .en    (rd_go),
    .count (rd_addr),
    .last  (rd_last_unused)
  );

  fb_addr_cnt #(.FRAME_LAST(FRAME_LAST)) u_wr_cnt (
    .clk   (clk),
    .reset (Reset_Main),
    .en    (wr_go),
    .count (wr_addr),
    .last  (wr_last)
  );

  // RAM port and handshake outputs are registered together with the state,
  // so the access decided at an edge appears on the RAM for the following
  // cycle. Address and data are left untouched in idle cycles so the RAM
  // inputs do not toggle needlessly. rd_valid follows the read cycle by one
  // because the RAM has one cycle of read latency.
  always_ff @(posedge clk) begin
    if (Reset_Main) begin
      ram_en         <= 1'b0;
      ram_we         <= 1'b0;
      ram_addr       <= '0;
      ram_din        <= '0;
      wr_ack         <= 1'b0;
      wr_frame_done  <= 1'b0;
      rd_valid       <= 1'b0;
      rd_frame_start <= 1'b0;
    end else begin
      ram_en         <= rd_go | wr_go;
      ram_we         <= wr_go;
      wr_ack         <= wr_go;
      wr_frame_done  <= wr_go & wr_last;
      rd_valid       <= (state == RD);
      rd_frame_start <= rd_go & (rd_addr == '0);
      if (rd_go) begin
        ram_addr <= rd_addr;
      end else if (wr_go) begin
        ram_addr <= wr_addr;
        ram_din  <= wr_data;
      end
    end
  end

`ifdef FB_ARB_STALL_CNT_EN
  // Counts cycles in which the writer asked but was refused; it saturates
  // rather than wrapping so a long stall never looks like a short one.
  always_ff @(posedge clk) begin
    if (Reset_Main) begin
      wr_stall_cnt <= '0;
    end else if (wr_req && !wr_go && (wr_stall_cnt != 16'hFFFF)) begin
      wr_stall_cnt <= wr_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// tb_fb_ram_arbiter -- self-checking bench for fb_ram_arbiter.
// Runs directed scenarios (reads, writes, priority stall, frame wrap,
// mid-frame reset) followed by random traffic; every cycle is compared
// against a pointer/queue-free arithmetic model of the arbiter rules.
// A small FRAME_LAST keeps frame wrap reachable in few cycles.
module tb_fb_ram_arbiter;

  localparam int DATA_W     = 8;
  localparam int FRAME_LAST = 19;
  localparam int FRAME_N    = FRAME_LAST + 1;

  logic              clk;
  logic              Reset_Main;
  logic              VtcVde;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_frame_done;
  logic              ram_en;
  logic              ram_we;
  logic [17:0]       ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              rd_valid;
  logic              rd_frame_start;
`ifdef FB_ARB_STALL_CNT_EN
  logic [15:0]       wr_stall_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  int m_rd_pos;
  int m_wr_pos;
  int m_prev_read;
  int e_en, e_we, e_addr, e_din, e_ack, e_done, e_valid, e_fstart, e_stall;

  fb_ram_arbiter #(
    .DATA_W     (DATA_W),
    .FRAME_LAST (FRAME_LAST)
  ) dut (
    .clk            (clk),
    .Reset_Main     (Reset_Main),
    .VtcVde         (VtcVde),
    .wr_req         (wr_req),
    .wr_data        (wr_data),
    .wr_ack         (wr_ack),
    .wr_frame_done  (wr_frame_done),
    .ram_en         (ram_en),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_din        (ram_din),
    .rd_valid       (rd_valid),
    .rd_frame_start (rd_frame_start)
`ifdef FB_ARB_STALL_CNT_EN
    ,
    .wr_stall_cnt   (wr_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: what the RAM port must show for the cycle after an
  // edge at which the given inputs were sampled.
  task automatic modelStep(input logic rst, input logic vde, input logic req,
                           input logic [DATA_W-1:0] data);
    if (rst) begin
      m_rd_pos = 0; m_wr_pos = 0; m_prev_read = 0;
      e_en = 0; e_we = 0; e_addr = 0; e_din = 0; e_ack = 0; e_done = 0;
      e_valid = 0; e_fstart = 0; e_stall = 0;
    end else begin
      e_valid  = m_prev_read;
      e_ack    = 0;
      e_done   = 0;
      e_fstart = 0;
      if (vde) begin
        e_en = 1; e_we = 0;
        e_addr   = m_rd_pos;
        e_fstart = (m_rd_pos == 0) ? 1 : 0;
        m_rd_pos = (m_rd_pos + 1) % FRAME_N;
        if (req && e_stall < 65535) e_stall = e_stall + 1;
      end else if (req) begin
        e_en = 1; e_we = 1; e_ack = 1;
        e_addr   = m_wr_pos;
        e_din    = int'(data);
        e_done   = (m_wr_pos == FRAME_LAST) ? 1 : 0;
        m_wr_pos = (m_wr_pos + 1) % FRAME_N;
      end else begin
        e_en = 0; e_we = 0;
      end
      m_prev_read = vde ? 1 : 0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("ram_en", 32'(ram_en), 32'(e_en));
    checkOutput("ram_we", 32'(ram_we), 32'(e_we));
    checkOutput("ram_addr", 32'(ram_addr), 32'(e_addr));
    checkOutput("ram_din", 32'(ram_din), 32'(e_din));
    checkOutput("wr_ack", 32'(wr_ack), 32'(e_ack));
    checkOutput("wr_frame_done", 32'(wr_frame_done), 32'(e_done));
    checkOutput("rd_valid", 32'(rd_valid), 32'(e_valid));
    checkOutput("rd_frame_start", 32'(rd_frame_start), 32'(e_fstart));
`ifdef FB_ARB_STALL_CNT_EN
    checkOutput("wr_stall_cnt", 32'(wr_stall_cnt), 32'(e_stall));
`endif
  endtask

  // Drive one cycle of inputs, let the edge happen, then check #1 later.
  task automatic applyStimulus(input logic rst, input logic vde, input logic req,
                               input logic [DATA_W-1:0] data);
    Reset_Main = rst;
    VtcVde     = vde;
    wr_req     = req;
    wr_data    = data;
    @(posedge clk);
    modelStep(rst, vde, req, data);
    #1;
    checkAll();
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic              hold;
    logic              r, v, q;

    Reset_Main = 1'b1; VtcVde = 1'b0; wr_req = 1'b0; wr_data = '0;
    m_rd_pos = 0; m_wr_pos = 0; m_prev_read = 0; e_stall = 0;

    // reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hA5);

    // three reads: addresses 0,1,2, frame start on 0, rd_valid trails
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // four back-to-back writes 0x11..0x14
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h11 + i));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // read priority: writer stalled five cycles, then lands at address 0
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'h5C);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h5C);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // frame wrap for reader and writer
    for (int i = 0; i < FRAME_N + 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < FRAME_N + 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));

    // mid-frame reset with a pending write, then both restart at 0
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h3C);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h3C);

    // random traffic; the writer holds its data until acknowledged
    hold = 1'b0;
    d    = '0;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 2) == 0);
      q = hold ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (!hold) d = 8'($urandom);
      applyStimulus(r, v, q, d);
      hold = q && !r && (e_ack == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
